// File: rtl/sym_mf_fir.sv
// Symmetric matched-filter FIR for the MSK receive path: folded pre-add, double-buffered taps,
// registered adder tree, round + saturate/wrap, output decimation. Define SYM_MF_SAT_EN to clamp.
module sym_mf_fir #(
    parameter int NTAPS = 41,
    parameter int WI    = 16,
    parameter int WC    = 16,
    parameter int WO    = 16,
    parameter int SHIFT = 15,
    parameter int DEC   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [WI-1:0]                i_in,
    input  logic signed [WI-1:0]                q_in,
    input  logic                                iq_val_i,
    input  logic                                coef_wr,
    input  logic [$clog2((NTAPS+1)/2)-1:0]      coef_addr,
    input  logic signed [WC-1:0]                coef_data,
    input  logic                                coef_commit,
    output logic signed [WO-1:0]                i_out,
    output logic signed [WO-1:0]                q_out,
    output logic                                iq_val_o,
    output logic                                sat_o
);
    localparam int NH    = (NTAPS + 1) / 2;
    localparam int L     = $clog2(NH);
    localparam int NP    = 1 << L;
    localparam int PW    = WI + 1;
    localparam int MW    = WI + WC + 1;
    localparam int ACC_W = MW + L;
    localparam int EW    = ACC_W + SHIFT + WO + 1;
    localparam int DCW   = (DEC > 1) ? $clog2(DEC) : 1;
    localparam logic signed [EW-1:0] RND = (EW'(1) << SHIFT) >> 1;
`ifdef SYM_MF_SAT_EN
    localparam logic signed [EW-1:0] SAT_MAX = (EW'(1) <<< (WO - 1)) - EW'(1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic signed [WI-1:0]    xi_q [NTAPS];
    logic signed [WI-1:0]    xq_q [NTAPS];
    logic signed [WC-1:0]    shadow_q [NH];
    logic signed [WC-1:0]    active_q [NH];
    logic signed [PW-1:0]    pi_d [NH];
    logic signed [PW-1:0]    pq_d [NH];
    logic signed [PW-1:0]    pi_q [NH];
    logic signed [PW-1:0]    pq_q [NH];
    logic signed [MW-1:0]    mi_d [NH];
    logic signed [MW-1:0]    mq_d [NH];
    // Heap-ordered tree: node n sums children 2n+1 / 2n+2, leaves at NP-1.., root at 0.
    logic signed [ACC_W-1:0] ti_q [2*NP-1];
    logic signed [ACC_W-1:0] tq_q [2*NP-1];
    logic [L+2:0]            vld_q;

    logic [DCW-1:0]          dec_cnt_q, dec_cnt_d;
    logic signed [WO-1:0]    i_out_q, i_out_d, q_out_q, q_out_d;
    logic                    val_o_q, val_o_d;
    logic                    sat_q, sat_d;
    logic signed [EW-1:0]    rsum_i, rsum_q;
    logic [WO-1:0]           res_i, res_q;
    logic                    ovf_i, ovf_q;

    genvar gi;
    generate
        for (gi = 0; gi < NH; gi++) begin : g_fold
            if (gi == NH - 1) begin : g_centre
                assign pi_d[gi] = {xi_q[gi][WI-1], xi_q[gi]};
                assign pq_d[gi] = {xq_q[gi][WI-1], xq_q[gi]};
            end else begin : g_pair
                assign pi_d[gi] = {xi_q[gi][WI-1], xi_q[gi]}
                                + {xi_q[NTAPS-1-gi][WI-1], xi_q[NTAPS-1-gi]};
                assign pq_d[gi] = {xq_q[gi][WI-1], xq_q[gi]}
                                + {xq_q[NTAPS-1-gi][WI-1], xq_q[NTAPS-1-gi]};
            end
            assign mi_d[gi] = MW'(pi_q[gi]) * MW'(active_q[gi]);
            assign mq_d[gi] = MW'(pq_q[gi]) * MW'(active_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                xi_q[k] <= '0;
                xq_q[k] <= '0;
            end
            for (int j = 0; j < NH; j++) begin
                shadow_q[j] <= '0;
                active_q[j] <= '0;
                pi_q[j]     <= '0;
                pq_q[j]     <= '0;
            end
            for (int n = 0; n < 2*NP-1; n++) begin
                ti_q[n] <= '0;
                tq_q[n] <= '0;
            end
            vld_q <= '0;
        end else begin
            if (iq_val_i) begin
                xi_q[0] <= i_in;
                xq_q[0] <= q_in;
                for (int k = 1; k < NTAPS; k++) begin
                    xi_q[k] <= xi_q[k-1];
                    xq_q[k] <= xq_q[k-1];
                end
            end
            if (coef_wr && (int'(coef_addr) < NH))
                shadow_q[coef_addr] <= coef_data;
            // Commit copies the shadow as it stood before any write in the same cycle.
            if (coef_commit)
                for (int j = 0; j < NH; j++)
                    active_q[j] <= shadow_q[j];
            for (int j = 0; j < NH; j++) begin
                pi_q[j]        <= pi_d[j];
                pq_q[j]        <= pq_d[j];
                ti_q[NP-1+j]   <= ACC_W'(mi_d[j]);
                tq_q[NP-1+j]   <= ACC_W'(mq_d[j]);
            end
            for (int j = NH; j < NP; j++) begin
                ti_q[NP-1+j] <= '0;
                tq_q[NP-1+j] <= '0;
            end
            for (int n = 0; n < NP-1; n++) begin
                ti_q[n] <= ti_q[2*n+1] + ti_q[2*n+2];
                tq_q[n] <= tq_q[2*n+1] + tq_q[2*n+2];
            end
            vld_q <= {vld_q[L+1:0], iq_val_i};
        end
    end

    function automatic logic [WO:0] fit(input logic signed [EW-1:0] v);
`ifdef SYM_MF_SAT_EN
        if (v > SAT_MAX)
            fit = {1'b1, SAT_MAX[WO-1:0]};
        else if (v < SAT_MIN)
            fit = {1'b1, SAT_MIN[WO-1:0]};
        else
            fit = {1'b0, v[WO-1:0]};
`else
        fit = {1'b0, v[WO-1:0]};
`endif
    endfunction

    always_comb begin
        rsum_i         = (EW'(ti_q[0]) + RND) >>> SHIFT;
        rsum_q         = (EW'(tq_q[0]) + RND) >>> SHIFT;
        {ovf_i, res_i} = fit(rsum_i);
        {ovf_q, res_q} = fit(rsum_q);
        dec_cnt_d      = dec_cnt_q;
        i_out_d        = i_out_q;
        q_out_d        = q_out_q;
        val_o_d        = 1'b0;
        sat_d          = sat_q;
        if (vld_q[L+2]) begin
            dec_cnt_d = (dec_cnt_q == DCW'(DEC - 1)) ? '0 : dec_cnt_q + 1'b1;
            if (dec_cnt_q == '0) begin
                i_out_d = res_i;
                q_out_d = res_q;
                val_o_d = 1'b1;
            end
            sat_d = sat_q | ovf_i | ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt_q <= '0;
            i_out_q   <= '0;
            q_out_q   <= '0;
            val_o_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            i_out_q   <= i_out_d;
            q_out_q   <= q_out_d;
            val_o_q   <= val_o_d;
            sat_q     <= sat_d;
        end
    end

    assign i_out    = i_out_q;
    assign q_out    = q_out_q;
    assign iq_val_o = val_o_q;
    assign sat_o    = sat_q;
endmodule

// File: tb/tb_sym_mf_fir.sv
// Directed bench for sym_mf_fir: a 5-tap, 24-bit DEC=1 instance and a 16-bit DEC=4 instance
// share the same stimulus; expected values are hand-computed tables.
module tb_sym_mf_fir;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic signed [15:0] i_in = '0, q_in = '0, coef_data = '0;
    logic               iq_val_i = 1'b0, coef_wr = 1'b0, coef_commit = 1'b0;
    logic [1:0]         coef_addr = '0;
    logic signed [23:0] a_i, a_q;
    logic signed [15:0] b_i, b_q;
    logic               a_val, a_sat, b_val, b_sat;

`ifdef SYM_MF_SAT_EN
    localparam int BIG_POS = 32767;
    localparam int SAT_ON  = 1;
`else
    localparam int BIG_POS = 5;
    localparam int SAT_ON  = 0;
`endif

    sym_mf_fir #(.NTAPS(5), .WI(16), .WC(16), .WO(24), .SHIFT(0), .DEC(1)) u_a (
        .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .iq_val_i(iq_val_i),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .i_out(a_i), .q_out(a_q), .iq_val_o(a_val), .sat_o(a_sat));

    sym_mf_fir #(.NTAPS(5), .WI(16), .WC(16), .WO(16), .SHIFT(0), .DEC(4)) u_b (
        .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .iq_val_i(iq_val_i),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .i_out(b_i), .q_out(b_q), .iq_val_o(b_val), .sat_o(b_sat));

    typedef struct { int c; int i; int q; } rec_t;
    rec_t qa[$], qb[$];
    int   capq[$], exp_i[$], exp_q[$];
    int   cyc = 0;
    int   total = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_val) qa.push_back('{cyc, int'(a_i), int'(a_q)});
            if (b_val) qb.push_back('{cyc, int'(b_i), int'(b_q)});
        end
    end

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step(input int i, input int q, input logic v,
                        input logic wr, input int addr, input int data, input logic cm);
        @(posedge clk);
        #1;
        i_in        = 16'(i);
        q_in        = 16'(q);
        iq_val_i    = v;
        coef_wr     = wr;
        coef_addr   = 2'(addr);
        coef_data   = 16'(data);
        coef_commit = cm;
        if (v) capq.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic load(input int c0, input int c1, input int c2);
        step(0, 0, 1'b0, 1'b1, 0, c0, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1, c1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 2, c2, 1'b0);
        step(0, 0, 1'b0, 1'b1, 3, 55, 1'b0);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic drain();
        idle(12);
        qa.delete(); qb.delete(); capq.delete(); exp_i.delete(); exp_q.delete();
    endtask

    // Impulse 100 on I, -7 on Q, then six zeros; gap=1 inserts a bubble before each zero.
    task automatic impulse(input int gap);
        step(100, -7, 1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (gap != 0) idle(1);
            step(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
        end
    endtask

    task automatic check_a(input string tag);
        idle(12);
        chk_eq({tag, "_count"}, qa.size(), exp_i.size());
        for (int k = 0; k < qa.size() && k < exp_i.size(); k++) begin
            chk_eq($sformatf("%s_i%0d", tag, k), qa[k].i, exp_i[k]);
            chk_eq($sformatf("%s_q%0d", tag, k), qa[k].q, exp_q[k]);
            if (k < capq.size())
                chk_eq($sformatf("%s_lat%0d", tag, k), qa[k].c - capq[k], 5);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_i_out", a_i, 0);
        chk_eq("rst_val", a_val, 0);
        chk_eq("rst_sat", b_sat, 0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp x[n]=n+1 through h=[1,2,3,2,1]; B keeps samples 0 and 4 only.
        load(1, 2, 3);
        for (int n = 0; n < 8; n++) step(n + 1, -(n + 1), 1'b1, 1'b0, 0, 0, 1'b0);
        exp_i = '{1, 4, 10, 18, 27, 36, 45, 54};
        exp_q = '{-1, -4, -10, -18, -27, -36, -45, -54};
        check_a("ramp");
        chk_eq("dec_count", qb.size(), 2);
        if (qb.size() == 2) begin
            chk_eq("dec_s0_i", qb[0].i, 1);
            chk_eq("dec_s4_i", qb[1].i, 27);
            chk_eq("dec_s4_q", qb[1].q, -27);
        end
        chk_eq("dec_hold", b_i, 27);
        repeat (5) step(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
        drain();

        impulse(0);
        exp_i = '{100, 200, 300, 200, 100, 0, 0};
        exp_q = '{-7, -14, -21, -14, -7, 0, 0};
        check_a("imp");
        drain();

        impulse(1);
        exp_i = '{100, 200, 300, 200, 100, 0, 0};
        exp_q = '{-7, -14, -21, -14, -7, 0, 0};
        check_a("bub");
        drain();

        // c2=6 committed mid-stream while c0=9 is written in the commit cycle.
        step(0, 0, 1'b0, 1'b1, 2, 6, 1'b0);
        step(100, -7, 1'b1, 1'b0, 0, 0, 1'b0);
        step(0, 0, 1'b1, 1'b1, 0, 9, 1'b1);
        repeat (5) step(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
        exp_i = '{100, 200, 600, 200, 100, 0, 0};
        exp_q = '{-7, -14, -42, -14, -7, 0, 0};
        check_a("cmt");
        drain();
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        impulse(0);
        exp_i = '{900, 200, 600, 200, 900, 0, 0};
        exp_q = '{-63, -14, -42, -14, -63, 0, 0};
        check_a("cmt2");
        drain();

        chk_eq("sat_pre", b_sat, 0);
        load(32767, 32767, 32767);
        repeat (12) step(32767, -32768, 1'b1, 1'b0, 0, 0, 1'b0);
        idle(12);
        chk_eq("sat_pos_seen", qb.size() > 0, 1);
        if (qb.size() > 0) begin
            chk_eq("sat_pos_i", qb[qb.size()-1].i, BIG_POS);
            chk_eq("sat_pos_q", qb[qb.size()-1].q, -32768);
        end
        chk_eq("sat_flag", b_sat, SAT_ON);
        drain();
        repeat (12) step(-32768, 32767, 1'b1, 1'b0, 0, 0, 1'b0);
        idle(12);
        chk_eq("sat_neg_seen", qb.size() > 0, 1);
        if (qb.size() > 0) begin
            chk_eq("sat_neg_i", qb[qb.size()-1].i, -32768);
            chk_eq("sat_neg_q", qb[qb.size()-1].q, BIG_POS);
        end
        chk_eq("sat_sticky", b_sat, SAT_ON);
        drain();

        // Asynchronous reset between edges with tokens in flight.
        repeat (3) step(50, 50, 1'b1, 1'b0, 0, 0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_eq("arst_a_i", a_i, 0);
        chk_eq("arst_b_i", b_i, 0);
        chk_eq("arst_val", a_val, 0);
        chk_eq("arst_sat", b_sat, 0);
        iq_val_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        qa.delete(); qb.delete(); capq.delete();
        impulse(0);
        exp_i = '{0, 0, 0, 0, 0, 0, 0};
        exp_q = '{0, 0, 0, 0, 0, 0, 0};
        check_a("rstc");
        drain();
        load(1, 2, 3);
        impulse(0);
        exp_i = '{100, 200, 300, 200, 100, 0, 0};
        exp_q = '{-7, -14, -21, -14, -7, 0, 0};
        check_a("rld");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sym_mf_fir.md
Name: sym_mf_fir

Overview:
- Parametrised symmetric-FIR matched filter for the MSK receive chain; next generation of the fixed-tap √RC simulation model, synthesisable.
- Sits between the front-end decimating FIR (I/Q at sample rate) and timing recovery.
- Runtime-loadable, double-buffered coefficients; symmetric pre-add folding; pipelined adder tree; rounding/saturation; optional output decimation.
- Generic in tap count, widths, shift and decimation, so half-sine / √RC / custom MSK taps use one block.

Parameters:
- NTAPS, 41, tap count; must be odd; NH = (NTAPS+1)/2 unique coefficients stored.
- WI, 16, I/Q input width (signed).
- WC, 16, coefficient width (signed).
- WO, 16, output width (signed).
- SHIFT, 15, LSB index of the full-precision sum selected for output.
- DEC, 1, output decimation factor (1 = every sample).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- i_in  in  WI  I sample.
- q_in  in  WI  Q sample.
- iq_val_i  in  1  input sample valid.
- coef_wr  in  1  shadow coefficient write strobe.
- coef_addr  in  $clog2(NH)  shadow coefficient index (0 = outermost tap).
- coef_data  in  WC  coefficient value.
- coef_commit  in  1  copy shadow bank to active bank.
- i_out  out  WO  filtered I.
- q_out  out  WO  filtered Q.
- iq_val_o  out  1  output valid.
- sat_o  out  1  sticky saturation flag.

Behaviour:
- Reset (async assert, sync release): delay lines, both coefficient banks, all pipeline registers, decimation counter and sat_o cleared. Outputs i_out/q_out = 0, iq_val_o = 0. Filter outputs 0 until the first commit.
- Delay line:
  - Shifts only when iq_val_i = 1; newest sample at x[0].
  - y[n] = sum over k = 0..NTAPS-1 of x[n-k]·h[k], where h[k] = h[NTAPS-1-k] = c[min(k, NTAPS-1-k)].
- Pipeline: free-running, not stalled. A valid token travels alongside the data. Bubbles on iq_val_i hold the delay line and produce no output.
  - Stage 1: pre-add x[k]+x[NTAPS-1-k], width WI+1; centre tap passes through unfolded.
  - Stage 2: multiply by the active coefficients, width WI+WC+1.
  - Stages 3..: one registered binary adder-tree level each, $clog2(NH) levels. Accumulator width ACC_W = WI+WC+1+$clog2(NH).
  - Final stage: round, then saturate or wrap.
- Latency: LAT = 3 + $clog2(NH) clocks from the iq_val_i edge to iq_val_o.
- Rounding:
  - Add 2^(SHIFT-1) when SHIFT > 0, round-half-up; then take bits [SHIFT+WO-1 : SHIFT].
  - SHIFT = 0 means no rounding.
- Coefficients:
  - coef_wr writes shadow[coef_addr].
  - coef_addr >= NH: write ignored.
  - coef_commit copies the entire shadow bank to the active bank at the end of that cycle.
  - coef_wr and coef_commit in the same cycle: the commit copies the pre-write shadow value; the new write waits for the next commit.
  - All products of one output are computed in one cycle (stage 2), so each output uses exactly one coefficient set. Samples reaching stage 2 in the cycle after a commit use the new set.
- Decimation:
  - Counter 0..DEC-1 advances per output token.
  - iq_val_o asserted only when the counter = 0; the first post-reset output is always emitted.
  - i_out/q_out hold their last emitted value between valids.
- sat_o: set on any I or Q saturation event; cleared only by rst.
- Reset mid-operation: in-flight tokens discarded; no iq_val_o until LAT clocks after the first post-reset iq_val_i.

Optional Feature:
- Macro: SYM_MF_SAT_EN.
- Defined: out-of-range results clamp to +(2^(WO-1)-1) / -(2^(WO-1)) and set sat_o.
- Undefined: results wrap (plain bit-select) and sat_o is tied to 0.

Test Plan:
- Impulse response:
  - Setup: NTAPS=5, SHIFT=0, DEC=1, WO=24; load c0=1, c1=2, c2=3, commit.
  - Stimulus: x=100, then zeros, continuous valid.
  - Required: outputs 100, 200, 300, 200, 100, then 0; first output LAT=5 clocks after the impulse. Q path checked with x=-7: -7, -14, -21, -14, -7.
- Bubbles:
  - Stimulus: same impulse with iq_val_i low every other cycle.
  - Required: identical output sequence; iq_val_o pattern delayed 5 clocks; no extra valids.
- Saturation (SYM_MF_SAT_EN defined):
  - Setup: WO=16, SHIFT=0, all c=32767.
  - Stimulus: constant x=32767.
  - Required: i_out=32767 and sat_o=1 (sticky). With x=-32768: i_out=-32768.
  - Macro undefined: wrapped low bits of the sum; sat_o=0.
- Decimation:
  - Setup: DEC=4.
  - Stimulus: 8 consecutive valids.
  - Required: exactly 2 iq_val_o pulses, carrying outputs for samples 0 and 4.
- Coefficient commit:
  - Stimulus: mid-stream, rewrite c2=6, commit; in the same cycle as a commit, write c0=9.
  - Required: each output matches exactly the old or the new set (centre 300 → 600); c0=9 not active until the next commit; write to addr 3 ignored.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously between clock edges.
  - Required: outputs 0 and iq_val_o=0 immediately; coefficients cleared (output 0 until reload + commit).
